dircc_link_buffer: RTL and testbench

- Avalon-ST packet buffer on every inter-node link of the DiRCC mesh.
- Takes one node's output_<dir>_* stream and drives the facing node's input_<opposite>_* stream (e.g. east output of node (x,y) to west input of node (x+1,y)).
- Decouples backpressure between nodes with a show-ahead FIFO.
- Enforces SOP/EOP framing so a downstream node never sees a beat outside a packet.

---
 rtl/dircc_link_pkg.sv | 19 +
 rtl/dircc_link_fifo_mem.sv | 23 ++
 rtl/dircc_link_buffer.sv | 134 +++++++++++++
 tb/tb_dircc_link_buffer.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dircc_link_pkg.sv
// Shared types for the DiRCC inter-node link buffer: beat layout, framing states, default widths.
package dircc_link_pkg;

   localparam int DEF_DATA_W  = 32;
   localparam int DEF_EMPTY_W = 2;

   typedef enum logic {
      IDLE   = 1'b0,
      IN_PKT = 1'b1
   } frame_state_e;

   typedef struct packed {
      logic [DEF_DATA_W-1:0]  data;
      logic                   sop;
      logic                   eop;
      logic [DEF_EMPTY_W-1:0] empty;
   } beat_t;

endpackage

// File: rtl/dircc_link_fifo_mem.sv
// Link buffer storage: DEPTH x WIDTH register array, synchronous write, asynchronous head read.
module dircc_link_fifo_mem #(
   parameter int WIDTH = 36,
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_addr] <= wr_data;
   end

   assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/dircc_link_buffer.sv
// DiRCC inter-node link buffer: show-ahead FIFO that enforces SOP/EOP framing on stored beats.
// Optional macro DIRCC_LINK_STORE_FORWARD_EN holds packets until their EOP is stored.
module dircc_link_buffer
   import dircc_link_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int EMPTY_W = DEF_EMPTY_W,
   parameter int DEPTH   = 16,
   parameter int CNT_W   = 16
) (
   input  logic                    clk_clk,
   input  logic                    reset_reset,
   input  logic [DATA_W-1:0]       in_data,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    in_startofpacket,
   input  logic                    in_endofpacket,
   input  logic [EMPTY_W-1:0]      in_empty,
   output logic [DATA_W-1:0]       out_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    out_startofpacket,
   output logic                    out_endofpacket,
   output logic [EMPTY_W-1:0]      out_empty,
   output logic [$clog2(DEPTH):0]  fill_level,
   output logic [CNT_W-1:0]        drop_count,
   output logic [CNT_W-1:0]        frame_err_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int EW = DATA_W + EMPTY_W + 2;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]      fill_q, fill_d;
   logic [CNT_W-1:0] drop_q, drop_d, ferr_q, ferr_d;
   frame_state_e     state_q, state_d;
   logic [EW-1:0]    wr_entry, head_entry;
   logic             full, empty, accept, store, head_valid, pop;

   assign full     = fill_q[AW];
   assign empty    = (fill_q == '0);
   assign in_ready = ~full & ~reset_reset;
   assign accept   = in_valid & in_ready;
   assign store    = accept & (in_startofpacket | (state_q == IN_PKT));
   assign wr_entry = {in_data, in_startofpacket, in_endofpacket, in_empty};
   assign pop      = head_valid & out_ready;

`ifdef DIRCC_LINK_STORE_FORWARD_EN
   logic [AW:0] pkt_cnt_q, pkt_cnt_d;
   logic        pkt_inc, pkt_dec;

   // full overrides the gate so a packet longer than DEPTH streams instead of wedging the link
   assign head_valid = ~empty & ((pkt_cnt_q != '0) | full);
   assign pkt_inc    = store & in_endofpacket;
   assign pkt_dec    = pop & head_entry[EMPTY_W];

   always_comb begin
      pkt_cnt_d = pkt_cnt_q;
      if (pkt_inc & ~pkt_dec)      pkt_cnt_d = pkt_cnt_q + 1'b1;
      else if (pkt_dec & ~pkt_inc) pkt_cnt_d = pkt_cnt_q - 1'b1;
   end

   always_ff @(posedge clk_clk) begin
      if (reset_reset) pkt_cnt_q <= '0;
      else             pkt_cnt_q <= pkt_cnt_d;
   end
`else
   assign head_valid = ~empty;
`endif

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      fill_d   = fill_q;
      drop_d   = drop_q;
      ferr_d   = ferr_q;
      state_d  = state_q;
      if (store) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
         state_d  = in_endofpacket ? IDLE : IN_PKT;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      if (store & ~pop)      fill_d = fill_q + 1'b1;
      else if (pop & ~store) fill_d = fill_q - 1'b1;
      if (accept & ~in_startofpacket & (state_q == IDLE))  drop_d = sat_inc(drop_q);
      if (accept & in_startofpacket & (state_q == IN_PKT)) ferr_d = sat_inc(ferr_q);
   end

   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         fill_q   <= '0;
         drop_q   <= '0;
         ferr_q   <= '0;
         state_q  <= IDLE;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         fill_q   <= fill_d;
         drop_q   <= drop_d;
         ferr_q   <= ferr_d;
         state_q  <= state_d;
      end
   end

   dircc_link_fifo_mem #(
      .WIDTH (EW),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk     (clk_clk),
      .wr_en   (store),
      .wr_addr (wr_ptr_q),
      .wr_data (wr_entry),
      .rd_addr (rd_ptr_q),
      .rd_data (head_entry)
   );

   // Storage is never reset, so the head fields are masked to zero whenever nothing is presented.
   assign out_valid         = head_valid;
   assign out_data          = head_valid ? head_entry[EW-1 -: DATA_W] : '0;
   assign out_startofpacket = head_valid & head_entry[EMPTY_W+1];
   assign out_endofpacket   = head_valid & head_entry[EMPTY_W];
   assign out_empty         = head_valid ? head_entry[EMPTY_W-1:0] : '0;
   assign fill_level        = fill_q;
   assign drop_count        = drop_q;
   assign frame_err_count   = ferr_q;

endmodule

// File: tb/tb_dircc_link_buffer.sv
// Testbench for dircc_link_buffer: directed scenarios plus randomized traffic against a queue model.
// Store-and-forward scenarios are compiled in when DIRCC_LINK_STORE_FORWARD_EN is defined.
module tb_dircc_link_buffer;

   localparam int DATA_W  = 32;
   localparam int EMPTY_W = 2;
   localparam int DEPTH   = 16;
   localparam int CNT_W   = 16;

   logic                 clk_clk = 1'b0;
   logic                 reset_reset = 1'b1;
   logic [DATA_W-1:0]    in_data = '0;
   logic                 in_valid = 1'b0;
   logic                 in_ready;
   logic                 in_startofpacket = 1'b0;
   logic                 in_endofpacket = 1'b0;
   logic [EMPTY_W-1:0]   in_empty = '0;
   logic [DATA_W-1:0]    out_data;
   logic                 out_valid;
   logic                 out_ready = 1'b0;
   logic                 out_startofpacket;
   logic                 out_endofpacket;
   logic [EMPTY_W-1:0]   out_empty;
   logic [4:0]           fill_level;
   logic [CNT_W-1:0]     drop_count;
   logic [CNT_W-1:0]     frame_err_count;

   int checks = 0;
   int failures = 0;

   always #5 clk_clk = ~clk_clk;

   dircc_link_buffer #(
      .DATA_W (DATA_W), .EMPTY_W (EMPTY_W), .DEPTH (DEPTH), .CNT_W (CNT_W)
   ) dut (
      .clk_clk (clk_clk), .reset_reset (reset_reset),
      .in_data (in_data), .in_valid (in_valid), .in_ready (in_ready),
      .in_startofpacket (in_startofpacket), .in_endofpacket (in_endofpacket), .in_empty (in_empty),
      .out_data (out_data), .out_valid (out_valid), .out_ready (out_ready),
      .out_startofpacket (out_startofpacket), .out_endofpacket (out_endofpacket), .out_empty (out_empty),
      .fill_level (fill_level), .drop_count (drop_count), .frame_err_count (frame_err_count)
   );

   // Reference model: queue of stored beats, framing flag and plain integer counters.
   typedef struct {
      logic [DATA_W-1:0]  data;
      logic               sop;
      logic               eop;
      logic [EMPTY_W-1:0] empty;
   } mbeat_t;

   mbeat_t mq[$];
   int     m_drop = 0;
   int     m_err = 0;
   bit     m_inpkt = 1'b0;

   function automatic bit m_out_valid();
      if (mq.size() == 0) return 1'b0;
`ifdef DIRCC_LINK_STORE_FORWARD_EN
      if (mq.size() == DEPTH) return 1'b1;
      foreach (mq[i]) if (mq[i].eop) return 1'b1;
      return 1'b0;
`else
      return 1'b1;
`endif
   endfunction

   always @(posedge clk_clk) begin : model
      bit     acc, pp;
      mbeat_t b;
      if (reset_reset) begin
         mq.delete();
         m_drop  = 0;
         m_err   = 0;
         m_inpkt = 1'b0;
      end else begin
         pp  = m_out_valid() && out_ready;
         acc = in_valid && (mq.size() < DEPTH);
         if (pp) void'(mq.pop_front());
         if (acc) begin
            b.data = in_data; b.sop = in_startofpacket; b.eop = in_endofpacket; b.empty = in_empty;
            if (in_startofpacket || m_inpkt) begin
               if (in_startofpacket && m_inpkt && m_err < 65535) m_err++;
               mq.push_back(b);
               m_inpkt = !in_endofpacket;
            end else if (m_drop < 65535) begin
               m_drop++;
            end
         end
      end
   end

   task automatic drive(input logic v, input logic s, input logic e, input logic [DATA_W-1:0] d,
                        input logic [EMPTY_W-1:0] emp, input logic rdy);
      @(negedge clk_clk);
      in_valid = v; in_startofpacket = s; in_endofpacket = e; in_data = d; in_empty = emp;
      out_ready = rdy;
      #1;
   endtask

   task automatic test_reset();
      reset_reset = 1'b1;
      drive(0, 0, 0, '0, '0, 0);
      drive(0, 0, 0, '0, '0, 0);
      checks += 6;
      if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
      if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      if (fill_level !== 5'd0) begin failures++; $display("FAIL reset_fill got=%0d exp=0", fill_level); end
      if (drop_count !== 16'd0) begin failures++; $display("FAIL reset_drop got=%0d exp=0", drop_count); end
      if (frame_err_count !== 16'd0) begin failures++; $display("FAIL reset_ferr got=%0d exp=0", frame_err_count); end
      if ({out_data, out_startofpacket, out_endofpacket, out_empty} !== '0) begin
         failures++; $display("FAIL reset_out_fields got=%h exp=0", out_data);
      end
      reset_reset = 1'b0;
      drive(0, 0, 0, '0, '0, 0);
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_in_ready got=%b exp=1", in_ready); end
   endtask

   task automatic test_three_beat();
      logic [DATA_W-1:0] exp_d [3];
      logic [3:0]        exp_f [3];
      logic [DATA_W-1:0] got_d[$];
      logic [3:0]        got_f[$];
      exp_d[0] = 32'h11; exp_d[1] = 32'h22; exp_d[2] = 32'h33;
      exp_f[0] = 4'b1000; exp_f[1] = 4'b0000; exp_f[2] = 4'b0110;
      for (int c = 0; c < 20; c++) begin
         if (c < 3) drive(1, exp_f[c][3], exp_f[c][2], exp_d[c], exp_f[c][1:0], 1);
         else       drive(0, 0, 0, '0, '0, 1);
         checks++;
         if (out_valid !== m_out_valid()) begin
            failures++; $display("FAIL three_beat_valid cyc=%0d got=%b exp=%b", c, out_valid, m_out_valid());
         end
         if (out_valid && out_ready) begin
            got_d.push_back(out_data);
            got_f.push_back({out_startofpacket, out_endofpacket, out_empty});
         end
      end
      checks++;
      if (got_d.size() != 3) begin failures++; $display("FAIL three_beat_count got=%0d exp=3", got_d.size()); end
      for (int i = 0; i < 3 && i < got_d.size(); i++) begin
         checks++;
         if (got_d[i] !== exp_d[i] || got_f[i] !== exp_f[i]) begin
            failures++;
            $display("FAIL three_beat_beat%0d got=%h/%b exp=%h/%b", i, got_d[i], got_f[i], exp_d[i], exp_f[i]);
         end
      end
      checks++;
      if (fill_level !== 5'd0) begin failures++; $display("FAIL three_beat_fill got=%0d exp=0", fill_level); end
   endtask

   task automatic test_fill_full();
      logic [DATA_W-1:0] got[$];
      for (int i = 0; i < DEPTH; i++) drive(1, 1, 1, 32'h100 + i, '0, 0);
      drive(0, 0, 0, '0, '0, 0);
      checks += 2;
      if (in_ready !== 1'b0) begin failures++; $display("FAIL full_in_ready got=%b exp=0", in_ready); end
      if (fill_level !== 5'd16) begin failures++; $display("FAIL full_fill got=%0d exp=16", fill_level); end
      for (int c = 0; c < 40 && got.size() < DEPTH; c++) begin
         drive(0, 0, 0, '0, '0, 1);
         if (c == 1) begin
            checks++;
            if (in_ready !== 1'b1) begin failures++; $display("FAIL full_ready_after_pop got=%b exp=1", in_ready); end
         end
         if (out_valid) got.push_back(out_data);
      end
      checks++;
      if (got.size() != DEPTH) begin failures++; $display("FAIL full_drain_count got=%0d exp=16", got.size()); end
      for (int i = 0; i < got.size(); i++) begin
         checks++;
         if (got[i] !== 32'h100 + i) begin
            failures++; $display("FAIL full_order idx=%0d got=%h exp=%h", i, got[i], 32'h100 + i);
         end
      end
   endtask

   task automatic test_drop();
      int                base;
      logic [DATA_W-1:0] got[$];
      base = drop_count;
      drive(1, 0, 0, 32'hAA, '0, 1);
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL drop_valid_a got=%b exp=0", out_valid); end
      drive(1, 0, 1, 32'hBB, '0, 1);
      drive(0, 0, 0, '0, '0, 1);
      checks += 3;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL drop_valid_b got=%b exp=0", out_valid); end
      if (fill_level !== 5'd0) begin failures++; $display("FAIL drop_fill got=%0d exp=0", fill_level); end
      if (int'(drop_count) != base + 2) begin
         failures++; $display("FAIL drop_count got=%0d exp=%0d", drop_count, base + 2);
      end
      for (int c = 0; c < 12; c++) begin
         if (c == 0)      drive(1, 1, 0, 32'h55, '0, 1);
         else if (c == 1) drive(1, 0, 1, 32'h66, 2'd1, 1);
         else             drive(0, 0, 0, '0, '0, 1);
         if (out_valid) got.push_back(out_data);
      end
      checks++;
      if (got.size() != 2 || got[0] !== 32'h55 || got[1] !== 32'h66) begin
         failures++; $display("FAIL drop_followup got_n=%0d exp=2 beats 55,66", got.size());
      end
   endtask

   task automatic test_frame_err();
      int base_e, base_d;
      logic [DATA_W-1:0] got_d[$];
      logic [1:0]        got_f[$];
      base_e = frame_err_count;
      drive(1, 1, 0, 32'h01, '0, 0);
      drive(1, 1, 1, 32'h02, '0, 0);
      drive(0, 0, 0, '0, '0, 0);
      base_d = drop_count;
      checks += 2;
      if (int'(frame_err_count) != base_e + 1) begin
         failures++; $display("FAIL ferr_count got=%0d exp=%0d", frame_err_count, base_e + 1);
      end
      if (fill_level !== 5'd2) begin failures++; $display("FAIL ferr_fill got=%0d exp=2", fill_level); end
      drive(1, 0, 1, 32'h77, '0, 0);
      drive(0, 0, 0, '0, '0, 0);
      checks += 2;
      if (int'(drop_count) != base_d + 1) begin
         failures++; $display("FAIL ferr_idle_drop got=%0d exp=%0d", drop_count, base_d + 1);
      end
      if (fill_level !== 5'd2) begin failures++; $display("FAIL ferr_idle_fill got=%0d exp=2", fill_level); end
      for (int c = 0; c < 10; c++) begin
         drive(0, 0, 0, '0, '0, 1);
         if (out_valid) begin got_d.push_back(out_data); got_f.push_back({out_startofpacket, out_endofpacket}); end
      end
      checks++;
      if (got_d.size() != 2 || got_d[0] !== 32'h01 || got_f[0] !== 2'b10 ||
          got_d[1] !== 32'h02 || got_f[1] !== 2'b11) begin
         failures++; $display("FAIL ferr_beats got_n=%0d exp=2 (01 sop, 02 sop+eop)", got_d.size());
      end
   endtask

   task automatic test_reset_mid_packet();
      int valid_seen;
      drive(1, 1, 0, 32'hA1, '0, 0);
      drive(1, 0, 0, 32'hA2, '0, 0);
      reset_reset = 1'b1;
      drive(0, 0, 0, '0, '0, 0);
      checks++;
      if (in_ready !== 1'b0) begin failures++; $display("FAIL midrst_in_ready got=%b exp=0", in_ready); end
      reset_reset = 1'b0;
      drive(0, 0, 0, '0, '0, 0);
      checks += 3;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", out_valid); end
      if (fill_level !== 5'd0) begin failures++; $display("FAIL midrst_fill got=%0d exp=0", fill_level); end
      if (in_ready !== 1'b1) begin failures++; $display("FAIL midrst_in_ready_after got=%b exp=1", in_ready); end
      valid_seen = 0;
      for (int c = 0; c < 8; c++) begin
         if (c == 0)      drive(1, 0, 0, 32'hA3, '0, 1);
         else if (c == 1) drive(1, 0, 1, 32'hA4, '0, 1);
         else             drive(0, 0, 0, '0, '0, 1);
         if (out_valid) valid_seen++;
      end
      checks += 2;
      if (valid_seen != 0) begin failures++; $display("FAIL midrst_stale got=%0d exp=0", valid_seen); end
      if (drop_count !== 16'd2) begin failures++; $display("FAIL midrst_drop got=%0d exp=2", drop_count); end
   endtask

`ifdef DIRCC_LINK_STORE_FORWARD_EN
   task automatic test_store_forward_stall();
      for (int c = 0; c < 7; c++) begin
         if (c % 2 == 0) drive(1, c == 0, c == 6, 32'hC0 + c / 2, '0, 1);
         else            drive(0, 0, 0, '0, '0, 1);
         checks++;
         if (out_valid !== 1'b0) begin failures++; $display("FAIL sf_hold cyc=%0d got=%b exp=0", c, out_valid); end
      end
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, 0, '0, '0, 1);
         checks++;
         if (out_valid !== 1'b1 || out_data !== 32'hC0 + i) begin
            failures++; $display("FAIL sf_burst idx=%0d got=%b/%h exp=1/%h", i, out_valid, out_data, 32'hC0 + i);
         end
      end
      drive(0, 0, 0, '0, '0, 1);
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL sf_after got=%b exp=0", out_valid); end
   endtask

   task automatic test_store_forward_oversize();
      int  sent, first_seen;
      logic [DATA_W-1:0] got[$];
      sent = 0; first_seen = 0;
      for (int c = 0; c < 300 && got.size() < 20; c++) begin
         if (sent < 20) drive(1, sent == 0, sent == 19, 32'hD00 + sent, '0, 1);
         else           drive(0, 0, 0, '0, '0, 1);
         if (in_valid && in_ready) sent++;
         if (out_valid && !first_seen) begin
            first_seen = 1;
            checks++;
            if (fill_level !== 5'd16) begin failures++; $display("FAIL sf_big_start fill got=%0d exp=16", fill_level); end
         end
         if (out_valid) got.push_back(out_data);
      end
      checks++;
      if (got.size() != 20) begin failures++; $display("FAIL sf_big_done got=%0d exp=20", got.size()); end
      for (int i = 0; i < got.size(); i++) begin
         checks++;
         if (got[i] !== 32'hD00 + i) begin failures++; $display("FAIL sf_big_order idx=%0d got=%h exp=%h", i, got[i], 32'hD00 + i); end
      end
   endtask
`endif

   task automatic test_random();
      reset_reset = 1'b1;
      drive(0, 0, 0, '0, '0, 0);
      reset_reset = 1'b0;
      for (int c = 0; c < 800; c++) begin
         reset_reset = ($urandom_range(0, 249) == 0);
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
               $urandom, 2'($urandom_range(0, 3)), $urandom_range(0, 3) != 0);
         checks += 5;
         if (out_valid !== m_out_valid()) begin
            failures++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", c, out_valid, m_out_valid());
         end
         if (in_ready !== (!reset_reset && mq.size() < DEPTH)) begin
            failures++; $display("FAIL rnd_in_ready cyc=%0d got=%b", c, in_ready);
         end
         if (fill_level !== 5'(mq.size())) begin
            failures++; $display("FAIL rnd_fill cyc=%0d got=%0d exp=%0d", c, fill_level, mq.size());
         end
         if (drop_count !== 16'(m_drop) || frame_err_count !== 16'(m_err)) begin
            failures++; $display("FAIL rnd_counters cyc=%0d got=%0d/%0d exp=%0d/%0d", c, drop_count, frame_err_count, m_drop, m_err);
         end
         if (m_out_valid() && {out_data, out_startofpacket, out_endofpacket, out_empty} !==
             {mq[0].data, mq[0].sop, mq[0].eop, mq[0].empty}) begin
            failures++; $display("FAIL rnd_head cyc=%0d got=%h exp=%h", c, out_data, mq[0].data);
         end
      end
      reset_reset = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_three_beat();
      test_fill_full();
      test_drop();
      test_frame_err();
      test_reset_mid_packet();
`ifdef DIRCC_LINK_STORE_FORWARD_EN
      test_store_forward_stall();
      test_store_forward_oversize();
`endif
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
